// File: rtl/rids_priority_resolver.sv
// rids_priority_resolver: picks the lowest valid rule ID, hit flag and match count per merged RIDS and queues results in a drop-on-full FIFO
module rids_priority_resolver #(
    parameter int NUM_RID        = 8,
    parameter int log_NUM_RID    = 3,
    parameter int RID_WIDTH      = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int log_FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [0:NUM_RID*RID_WIDTH-1]    in,
    input  logic                            in_valid,
    output logic [RID_WIDTH-1:0]            out_rid,
    output logic                            out_hit,
    output logic [log_NUM_RID:0]            out_count,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            overflow
);
    typedef struct packed {
        logic [RID_WIDTH-1:0] rid;
        logic                 hit;
        logic [log_NUM_RID:0] count;
    } res_t;
    localparam res_t empty_res = '{rid: '1, hit: 1'b0, count: '0};
    localparam logic [log_FIFO_DEPTH:0] full_occ = (log_FIFO_DEPTH+1)'(FIFO_DEPTH);
    logic [0:NUM_RID*RID_WIDTH-1] s1_data;
    logic                         s1_valid;
    logic [RID_WIDTH-1:0]         tree [0:2*NUM_RID-2];
    res_t                         res;
    res_t                         mem [0:FIFO_DEPTH-1];
    logic [log_FIFO_DEPTH-1:0]    rd_ptr, wr_ptr;
    logic [log_FIFO_DEPTH:0]      occ;
    logic                         pop, push;
    // stage 1: capture the incoming RIDS and its valid
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '1;
        end else begin
            s1_valid <= in_valid;
            s1_data  <= in;
        end
    end
    // heap-shaped min tree over the slots; all-ones empties lose every compare
    always_comb begin
        tree = '{default: '1};
        res = empty_res;
        res.count = '0;
        for (int i = 0; i < NUM_RID; i++) begin
            tree[NUM_RID-1+i] = s1_data[i*RID_WIDTH +: RID_WIDTH];
            res.count = res.count + (log_NUM_RID+1)'(tree[NUM_RID-1+i] != '1);
        end
        for (int j = NUM_RID-2; j >= 0; j--)
            tree[j] = (tree[2*j+1] < tree[2*j+2]) ? tree[2*j+1] : tree[2*j+2];
        res.rid = tree[0];
        res.hit = res.count != '0;
    end
    // pop only a valid head; a full FIFO accepts a push only alongside a pop
    always_comb begin
        out_valid = occ != '0;
        pop = out_valid && out_ready;
        push = s1_valid && (occ != full_occ || pop);
        {out_rid, out_hit, out_count} = out_valid ? mem[rd_ptr] : empty_res;
    end
    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= res;
    end
    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + (log_FIFO_DEPTH+1)'(push) - (log_FIFO_DEPTH+1)'(pop);
            if (s1_valid && !push) overflow <= 1'b1;
        end
    end
endmodule
